ad9250_dma_pack: RTL and testbench
==================================

AD9250_DMA_PACK -- requirements
Module: ad9250_dma_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of 64-bit FIFO words; power of two, 4..256.
REQ-002 SHALL have parameter PKT_WORDS, default 256, number of words per DMA packet; 2..65536.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: adc_clk  input  1  sample clock; adc_rstn  input  1  async active-low reset.
REQ-004 SHALL have these channel A inputs: adc_valid_a  input  1  sample valid; adc_enable_a  input  1  channel enabled; adc_data_a  input  32  {sample1,sample0}, 16 bits each.
REQ-005 SHALL have these channel B inputs: adc_valid_b  input  1; adc_enable_b  input  1; adc_data_b  input  32; same meaning as channel A.
REQ-006 SHALL have adc_dovf  output  1  overflow pulse, routed to the ADC core status.
REQ-007 SHALL have these DMA outputs and input: dma_valid  output  1; dma_data  output  64; dma_last  output  1; dma_ready  input  1.
REQ-008 SHALL have fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-009 A sample beat SHALL be a cycle with adc_valid_a & adc_valid_b both high; beats with only one valid high are ignored.
REQ-010 With both channels enabled, each beat SHALL produce one word {adc_data_b, adc_data_a}.
REQ-011 With exactly one channel enabled, beats SHALL alternate a phase bit:
- phase 0 holds the enabled channel's 32 bits;
- phase 1 produces word {current, held}.
REQ-012 With no channel enabled, no word SHALL be produced.
REQ-013 Any change of {adc_enable_b, adc_enable_a} SHALL clear the phase bit and discard the held half-word in the cycle of the change; a beat in that cycle is packed under the new enables.
REQ-014 A produced word SHALL be written to the FIFO on the same edge iff fifo_level < FIFO_DEPTH, evaluated before any same-cycle read.
REQ-015 If the FIFO is full, the word SHALL be dropped and adc_dovf pulsed high for exactly that one cycle.
REQ-016 On read side, dma_valid SHALL assert whenever the FIFO is non-empty.
REQ-017 dma_data SHALL come from a registered output stage.
REQ-018 Latency from the producing beat edge to dma_valid high SHALL be 2 cycles when the FIFO is empty.
REQ-019 A transfer SHALL occur iff dma_valid & dma_ready.
REQ-020 While dma_valid & !dma_ready, dma_data and dma_last SHALL hold stable.
REQ-021 Simultaneous write and read SHALL leave fifo_level unchanged.
REQ-022 fifo_level SHALL never exceed FIFO_DEPTH or underflow.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Word order on dma_data SHALL equal production order; no reordering and no duplication.

Reset
REQ-025 Asserting adc_rstn low SHALL immediately force the following to 0: dma_valid, dma_data, dma_last, adc_dovf, fifo_level, pointers, phase bit, held half-word and packet counter.
REQ-026 Reset mid-transfer SHALL discard FIFO contents.
REQ-027 After reset release, the first beat SHALL be treated as phase 0.

Configuration
REQ-028 Macro AD9250_DMA_PACK_LAST_EN SHALL control dma_last.
- Defined: a packet counter counts transfers, and dma_last is high on every PKT_WORDS-th transferred word; the counter wraps to 0 after the last word.
- Undefined: dma_last is constant 0 and no counter logic exists.

Structure
REQ-029 A shared package ad9250_pack_pkg SHALL hold:
- the packed word width constant (64);
- the sample width constant (16);
- the enable-mode enumeration: NONE, A_ONLY, B_ONLY, BOTH.
REQ-030 The FIFO SHALL be one sub-module, ad9250_pack_fifo, with single clock, registered output and level count; packing logic stays in the top.

Verification
REQ-031 Both enabled, 4 beats A=0x0000_0001.., B=0x1000_0001.., dma_ready=1 -> 4 words {B,A} in order, first dma_valid 2 cycles after beat 1.
REQ-032 A only, beats A=0x11112222, 0x33334444 -> one word 0x33334444_11112222; B data ignored.
REQ-033 dma_ready=0, FIFO_DEPTH=16, 18 both-enabled beats -> fifo_level=16, adc_dovf high exactly on beats 17 and 18; the first 16 words drain intact.
REQ-034 A only, 1 beat, then enable B -> held half discarded; next beat yields {B,A} of that beat only.
REQ-035 Macro defined, PKT_WORDS=4, 8 beats -> dma_last high on words 4 and 8; macro undefined -> dma_last stays 0.
REQ-036 adc_rstn low with 5 words queued -> dma_valid=0 and fifo_level=0 in the same cycle, no stale word after release.

Source files
------------

// File: rtl/ad9250_pack_pkg.sv
// ad9250_pack_pkg: shared word/sample widths and channel enable modes for the AD9250 DMA packer
package ad9250_pack_pkg;
   localparam int WORD_W   = 64;
   localparam int SAMPLE_W = 16;
   localparam int CH_W     = 2 * SAMPLE_W;
   typedef enum logic [1:0] {NONE = 2'b00, A_ONLY = 2'b01, B_ONLY = 2'b10, BOTH = 2'b11} mode_t;
endpackage

// File: rtl/ad9250_dma_pack_if.sv
// ad9250_dma_pack_if: valid/ready DMA word stream with optional packet-last marker
interface ad9250_dma_pack_if;
   import ad9250_pack_pkg::*;
   logic              valid;
   logic [WORD_W-1:0] data;
   logic              last;
   logic              ready;
   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/ad9250_pack_fifo.sv
// ad9250_pack_fifo: single-clock word FIFO with registered output stage and occupancy count
module ad9250_pack_fifo
   import ad9250_pack_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_req,
   input  logic [WORD_W-1:0]        wr_data,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [WORD_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, wr_ptr_q, rd_ptr;
   logic              wr_en, xfer, load;
   // the output stage only sees words one edge after they land, like a registered RAM read
   always_comb begin
      full  = level == (AW+1)'(DEPTH);
      wr_en = wr_req & ~full;
      xfer  = rd_valid & rd_ready;
      load  = (rd_ptr != wr_ptr_q) & (~rd_valid | rd_ready);
   end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         wr_ptr_q <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         wr_ptr   <= wr_ptr + (AW+1)'(wr_en);
         wr_ptr_q <= wr_ptr;
         rd_ptr   <= rd_ptr + (AW+1)'(load);
         level    <= level + (AW+1)'(wr_en) - (AW+1)'(xfer);
         if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_ptr[AW-1:0]];
         end else if (xfer) rd_valid <= 1'b0;
      end
endmodule

// File: rtl/ad9250_dma_pack.sv
// ad9250_dma_pack: packs AD9250 A/B samples into 64-bit DMA words; AD9250_DMA_PACK_LAST_EN enables dma_last framing
module ad9250_dma_pack
   import ad9250_pack_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int PKT_WORDS  = 256
) (
   input  logic                          adc_clk,
   input  logic                          adc_rstn,
   input  logic                          adc_valid_a,
   input  logic                          adc_enable_a,
   input  logic [CH_W-1:0]               adc_data_a,
   input  logic                          adc_valid_b,
   input  logic                          adc_enable_b,
   input  logic [CH_W-1:0]               adc_data_b,
   output logic                          adc_dovf,
   ad9250_dma_pack_if.master             dma,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   mode_t             mode, mode_q;
   logic              chg, beat, single, phase, ph, word_vld, full;
   logic [CH_W-1:0]   held, sel;
   logic [WORD_W-1:0] word;
   // an enable change restarts the pairing so the beat in that cycle is packed under the new mode
   always_comb begin
      mode     = mode_t'({adc_enable_b, adc_enable_a});
      chg      = mode != mode_q;
      beat     = adc_valid_a & adc_valid_b;
      single   = mode == A_ONLY || mode == B_ONLY;
      ph       = phase & ~chg;
      sel      = adc_enable_a ? adc_data_a : adc_data_b;
      word_vld = beat & (mode == BOTH || (single & ph));
      word     = mode == BOTH ? {adc_data_b, adc_data_a} : {sel, held};
   end
   always_ff @(posedge adc_clk or negedge adc_rstn)
      if (!adc_rstn) begin
         mode_q   <= NONE;
         phase    <= 1'b0;
         held     <= '0;
         adc_dovf <= 1'b0;
      end else begin
         mode_q   <= mode;
         phase    <= (single & beat) ? ~ph : ph;
         held     <= (single & beat & ~ph) ? sel : (chg ? '0 : held);
         adc_dovf <= word_vld & full;
      end
   ad9250_pack_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (adc_clk),
      .rst_n    (adc_rstn),
      .wr_req   (word_vld),
      .wr_data  (word),
      .rd_ready (dma.ready),
      .rd_valid (dma.valid),
      .rd_data  (dma.data),
      .level    (fifo_level),
      .full     (full)
   );
`ifdef AD9250_DMA_PACK_LAST_EN
   localparam int CW = $clog2(PKT_WORDS);
   logic [CW-1:0] pkt_cnt;
   logic          pkt_end;
   always_comb begin
      pkt_end  = pkt_cnt == CW'(PKT_WORDS - 1);
      dma.last = dma.valid & pkt_end;
   end
   always_ff @(posedge adc_clk or negedge adc_rstn)
      if (!adc_rstn) pkt_cnt <= '0;
      else if (dma.valid & dma.ready) pkt_cnt <= pkt_end ? '0 : pkt_cnt + CW'(1);
`else
   always_comb dma.last = 1'b0;
`endif
endmodule

// File: tb/tb_ad9250_dma_pack.sv
// tb_ad9250_dma_pack: directed self-checking bench for ad9250_dma_pack (FIFO_DEPTH=16, PKT_WORDS=4)
module tb_ad9250_dma_pack;
   logic        clk = 1'b0;
   logic        rstn;
   logic        va, vb, ea, eb;
   logic [31:0] da, db;
   logic        dovf;
   logic [4:0]  lvl;
   int          tests = 0;
   int          fails = 0;
`ifdef AD9250_DMA_PACK_LAST_EN
   localparam bit LE = 1'b1;
`else
   localparam bit LE = 1'b0;
`endif
   ad9250_dma_pack_if dma ();
   ad9250_dma_pack #(.FIFO_DEPTH(16), .PKT_WORDS(4)) dut (
      .adc_clk      (clk),
      .adc_rstn     (rstn),
      .adc_valid_a  (va),
      .adc_enable_a (ea),
      .adc_data_a   (da),
      .adc_valid_b  (vb),
      .adc_enable_b (eb),
      .adc_data_b   (db),
      .adc_dovf     (dovf),
      .dma          (dma),
      .fifo_level   (lvl)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic [31:0] a, input logic [31:0] b);
      va = 1'b1;
      vb = 1'b1;
      da = a;
      db = b;
   endtask
   task automatic idle;
      va = 1'b0;
      vb = 1'b0;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      rstn = 1'b0;
      va = 1'b0; vb = 1'b0; ea = 1'b0; eb = 1'b0; da = '0; db = '0;
      dma.ready = 1'b1;
      tick; tick;
      chk("rst_valid", 64'(dma.valid), 64'd0);
      chk("rst_level", 64'(lvl), 64'd0);
      chk("rst_dovf", 64'(dovf), 64'd0);
      chk("rst_data", dma.data, 64'd0);
      chk("rst_last", 64'(dma.last), 64'd0);
      rstn = 1'b1;
      ea = 1'b1; eb = 1'b1;
      tick;
      beat(32'h0000_0001, 32'h1000_0001); tick;
      chk("lat_e0", 64'(dma.valid), 64'd0);
      beat(32'h0000_0002, 32'h1000_0002); tick;
      chk("lat_e1", 64'(dma.valid), 64'd0);
      beat(32'h0000_0003, 32'h1000_0003); tick;
      chk("lat_e2", 64'(dma.valid), 64'd1);
      chk("both_w1", dma.data, 64'h1000_0001_0000_0001);
      chk("both_last1", 64'(dma.last), 64'd0);
      beat(32'h0000_0004, 32'h1000_0004); tick;
      chk("both_w2", dma.data, 64'h1000_0002_0000_0002);
      chk("both_lvl", 64'(lvl), 64'd3);
      idle; tick;
      chk("both_w3", dma.data, 64'h1000_0003_0000_0003);
      tick;
      chk("both_w4", dma.data, 64'h1000_0004_0000_0004);
      chk("both_last4", 64'(dma.last), 64'(LE));
      tick;
      chk("both_empty", 64'(dma.valid), 64'd0);
      chk("both_lvl0", 64'(lvl), 64'd0);
      ea = 1'b1; eb = 1'b0; tick;
      beat(32'h1111_2222, 32'hDEAD_BEEF); tick;
      chk("aonly_hold", 64'(lvl), 64'd0);
      beat(32'h3333_4444, 32'hCAFE_F00D); tick;
      idle; tick; tick;
      chk("aonly_valid", 64'(dma.valid), 64'd1);
      chk("aonly_word", dma.data, 64'h3333_4444_1111_2222);
      chk("aonly_last", 64'(dma.last), 64'd0);
      tick;
      chk("aonly_single", 64'(dma.valid), 64'd0);
      ea = 1'b0; eb = 1'b1; tick;
      beat(32'hDEAD_BEEF, 32'hAAAA_0001); tick;
      beat(32'h0000_0000, 32'hAAAA_0002); tick;
      idle; tick; tick;
      chk("bonly_word", dma.data, 64'hAAAA_0002_AAAA_0001);
      tick;
      ea = 1'b1; eb = 1'b0; tick;
      beat(32'h5555_6666, 32'h1234_5678); tick;
      chk("chg_hold", 64'(lvl), 64'd0);
      ea = 1'b1; eb = 1'b1;
      beat(32'h7777_8888, 32'h9999_AAAA); tick;
      idle; tick; tick;
      chk("chg_word", dma.data, 64'h9999_AAAA_7777_8888);
      chk("chg_last", 64'(dma.last), 64'd0);
      tick;
      chk("chg_nodup", 64'(dma.valid), 64'd0);
      beat(32'h0000_0008, 32'h8000_0008); tick;
      idle; tick; tick;
      chk("w8_word", dma.data, 64'h8000_0008_0000_0008);
      chk("w8_last", 64'(dma.last), 64'(LE));
      tick;
      dma.ready = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         beat(32'(k), 32'hB000_0000 | 32'(k)); tick;
         chk($sformatf("ovf_beat%0d", k), 64'(dovf), 64'(k > 16));
      end
      idle; tick;
      chk("ovf_pulse_end", 64'(dovf), 64'd0);
      chk("ovf_level", 64'(lvl), 64'd16);
      dma.ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("drain_valid%0d", i), 64'(dma.valid), 64'd1);
         chk($sformatf("drain_word%0d", i), dma.data, {32'hB000_0000 | 32'(i), 32'(i)});
         chk($sformatf("drain_last%0d", i), 64'(dma.last), 64'(LE & (i % 4 == 0)));
         tick;
      end
      chk("drain_empty", 64'(dma.valid), 64'd0);
      chk("drain_lvl0", 64'(lvl), 64'd0);
      dma.ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         beat(32'hC000_0000 | 32'(k), 32'hD000_0000 | 32'(k)); tick;
      end
      idle; tick; tick;
      chk("mid_level5", 64'(lvl), 64'd5);
      chk("mid_valid", 64'(dma.valid), 64'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(dma.valid), 64'd0);
      chk("mid_rst_level", 64'(lvl), 64'd0);
      chk("mid_rst_data", dma.data, 64'd0);
      tick;
      rstn = 1'b1;
      dma.ready = 1'b1;
      ea = 1'b1; eb = 1'b0;
      tick; tick; tick;
      chk("nostale_valid", 64'(dma.valid), 64'd0);
      chk("nostale_level", 64'(lvl), 64'd0);
      beat(32'hE1E1_E1E1, 32'h0000_0000); tick;
      beat(32'hE2E2_E2E2, 32'h0000_0000); tick;
      idle; tick; tick;
      chk("post_rst_valid", 64'(dma.valid), 64'd1);
      chk("post_rst_word", dma.data, 64'hE2E2_E2E2_E1E1_E1E1);
      chk("post_rst_last", 64'(dma.last), 64'd0);
      tick;
      chk("post_rst_empty", 64'(dma.valid), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
